series_accumulator: RTL and testbench
=====================================

Name: series_accumulator

Overview:
- Parametrised successor to the single-mode summing adder.
- On `enable`, it accumulates a selectable integer series over k = 0..count, one term per step strobe.
- It then converts the result to BCD sequentially (shift-add-3) and drives DIGITS seven-segment digits.
- It sits between the board switches and the 7-segment bank; it runs entirely in the `clk` domain and uses an internal step-enable, not a derived clock.

Parameters:
- N_BITS, 4: width of `count`.
- SUM_W, 8: accumulator width; result saturates at 2^SUM_W-1.
- DIGITS, 3: number of 7-segment digits driven. Constraint: 10^DIGITS > 2^SUM_W-1.
- STEP_DIV, 1: `clk` cycles per accumulation step; 1 means every cycle. Must be at least 1.

Ports:
- clk  in  1  system clock; every register on rising edge.
- rst_a_p  in  1  reset, synchronous, active-high.
- enable  in  1  level; start request, and hold to keep the result displayed.
- count  in  N_BITS  last term index; latched on IDLE->SUM.
- mode  in  2  series select; latched on IDLE->SUM.
- seg  out  7*DIGITS  digit i = seg[7*i+6 : 7*i], units at i=0. Bit order a..g with bit 6=a. Active-high, 1 = lit.
- busy  out  1  high in SUM and CONV.
- done  out  1  high in PRINT.
- overflow  out  1  saturation occurred in the displayed result.

Behaviour:
- Reset (`rst_a_p`=1 at an edge):
  - state=IDLE; busy=0, done=0, overflow=0.
  - acc=0, k=0, prescaler=0.
  - BCD register=0, so seg shows "0" on every digit (0000000 on blanked digits with LEADING_BLANK_EN).
  - Reset has priority over all other events, in any state including mid-SUM or mid-CONV.
- Terms f(k) by mode:
  - 00: k.
  - 01: k*k (2*N_BITS-bit product).
  - 10: 2k+1 (odd numbers).
  - 11: 2k (even numbers).
- Addition is SUM_W+1 bits wide. If the result exceeds 2^SUM_W-1, acc=2^SUM_W-1 and overflow_int=1; acc then stays saturated.
- Step strobe: prescaler counts 0..STEP_DIV-1 while in SUM, and strobe=1 when it reaches STEP_DIV-1. Prescaler clears on IDLE->SUM.
- IDLE:
  - Entered with `enable`=1 at an edge -> go to SUM; latch count and mode; acc=0, k=0, overflow_int=0.
  - Display keeps the previous result.
- SUM, on each strobe:
  - If k<=count_l: acc+=f(k), k++.
  - Else: go to CONV and load the shift register with acc.
  - k is N_BITS+1 bits wide, so count=2^N_BITS-1 terminates correctly.
- CONV:
  - Exactly SUM_W cycles of shift-add-3 (one cycle per bit, no strobe dependency).
  - After the last cycle -> PRINT. At the same edge the BCD result goes to the display register and overflow <= overflow_int.
- PRINT: done=1; seg is stable. `enable`=0 -> IDLE, with the display retained.
- `enable`=0 during SUM or CONV: abort to IDLE next edge. acc, k and conversion are discarded; display and overflow are unchanged.
- Changes to count or mode outside IDLE have no effect.
- Latency with STEP_DIV=1: edge 0 samples `enable` in IDLE. done is high after edge count+2+SUM_W (count=4, SUM_W=8 -> edge 14).
- Segment codes (abcdefg):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
- seg and the status outputs are registered, with no combinational path from inputs.

Optional Feature:
- Macro: LEADING_BLANK_EN.
- Defined: any digit above the most significant non-zero digit shows 0000000. Digit 0 always shows a value, so result 0 shows " 0".
- Undefined: all DIGITS show their value with leading zeros, e.g. 10 -> "010".
- Blanking is computed at the CONV->PRINT load, so it adds no latency.

Test Plan:
- Reset only -> seg digits all 1111110 (or digits 2..1 = 0000000 with LEADING_BLANK_EN); busy=0, done=0, overflow=0.
- mode=00, count=4, enable=1 held -> done at edge 14; seg = "010" (0110000 on digit 1, 1111110 on digit 0); overflow=0.
- mode=00, count=15 -> 120. mode=01, count=5 -> 55. mode=10, count=3 -> 16 (1+3+5+7).
- mode=01, count=15 (sum would be 1240) -> "255", overflow=1. A following run with mode=00, count=2 -> "003", overflow=0.
- STEP_DIV=4, mode=00, count=4: drop enable 6 cycles into SUM -> IDLE next edge, busy=0, display unchanged. Re-raise enable -> the run restarts from k=0.
- Assert `rst_a_p` for one cycle mid-CONV -> IDLE next edge, display "000", done=0. Change count/mode while in PRINT -> seg unchanged.

Source files
------------

// File: rtl/series_accumulator.sv
// series_accumulator: sums a selectable integer series over k = 0..count, converts the result to
// BCD by sequential shift-add-3 and drives a 7-segment bank. Optional macro: LEADING_BLANK_EN.
module series_accumulator #(
    parameter int unsigned N_BITS   = 4,
    parameter int unsigned SUM_W    = 8,
    parameter int unsigned DIGITS   = 3,
    parameter int unsigned STEP_DIV = 1
) (
    input  logic                clk,
    input  logic                rst_a_p,
    input  logic                enable,
    input  logic [N_BITS-1:0]   count,
    input  logic [1:0]          mode,
    output logic [7*DIGITS-1:0] seg,
    output logic                busy,
    output logic                done,
    output logic                overflow
);

    localparam int unsigned SEG_W   = 7 * DIGITS;
    localparam int unsigned BCD_W   = 4 * DIGITS;
    localparam int unsigned K_W     = N_BITS + 1;
    localparam int unsigned TERM_W  = 2 * N_BITS + 1;
    localparam int unsigned ADD_W   = ((SUM_W > TERM_W) ? SUM_W : TERM_W) + 1;
    localparam int unsigned PRESC_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned CNT_W   = $clog2(SUM_W);

    localparam logic [SUM_W-1:0] SAT      = {SUM_W{1'b1}};
    localparam logic [6:0]       SEG_ZERO = 7'b1111110;
`ifdef LEADING_BLANK_EN
    localparam logic [SEG_W-1:0] SEG_RESET = SEG_W'(SEG_ZERO);
`else
    localparam logic [SEG_W-1:0] SEG_RESET = {DIGITS{SEG_ZERO}};
`endif

    typedef enum logic [1:0] {StIdle, StSum, StConv, StPrint} state_e;

    state_e              state_q, state_d;
    logic [N_BITS-1:0]   count_q, count_d;
    logic [1:0]          mode_q, mode_d;
    logic [SUM_W-1:0]    acc_q, acc_d;
    logic [K_W-1:0]      k_q, k_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic                ovf_int_q, ovf_int_d;
    logic [SUM_W-1:0]    bin_q, bin_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [SEG_W-1:0]    seg_q, seg_d;
    logic                overflow_q, overflow_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                      strobe;
    logic [N_BITS-1:0]         k_lo;
    logic [2*N_BITS-1:0]       sq;
    logic [ADD_W-1:0]          term;
    logic [ADD_W-1:0]          sum;
    logic                      sum_sat;
    logic [BCD_W-1:0]          bcd_adj;
    logic [BCD_W+SUM_W-1:0]    shifted;
    logic [BCD_W-1:0]          bcd_sh;
    logic [SUM_W-1:0]          bin_sh;
    logic [SEG_W-1:0]          seg_new;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1111110;
            4'd1:    seg7 = 7'b0110000;
            4'd2:    seg7 = 7'b1101101;
            4'd3:    seg7 = 7'b1111001;
            4'd4:    seg7 = 7'b0110011;
            4'd5:    seg7 = 7'b1011011;
            4'd6:    seg7 = 7'b1011111;
            4'd7:    seg7 = 7'b1110000;
            4'd8:    seg7 = 7'b1111111;
            4'd9:    seg7 = 7'b1111011;
            default: seg7 = 7'b0000000;
        endcase
    endfunction

    assign strobe = (presc_q == PRESC_W'(STEP_DIV - 1));

    // Term generation; k never exceeds count while adding, so its low bits suffice for k*k.
    assign k_lo = k_q[N_BITS-1:0];
    assign sq   = {{N_BITS{1'b0}}, k_lo} * {{N_BITS{1'b0}}, k_lo};

    always_comb begin
        term = '0;
        case (mode_q)
            2'b00:   term = ADD_W'(k_q);
            2'b01:   term = ADD_W'(sq);
            2'b10:   term = ADD_W'({k_q, 1'b1});
            default: term = ADD_W'({k_q, 1'b0});
        endcase
    end

    assign sum     = ADD_W'(acc_q) + term;
    assign sum_sat = (sum > ADD_W'(SAT));

    // One shift-add-3 step: correct every BCD digit >= 5, then shift {bcd, bin} left by one.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign shifted = {bcd_adj, bin_q} << 1;
    assign bcd_sh  = shifted[BCD_W+SUM_W-1:SUM_W];
    assign bin_sh  = shifted[SUM_W-1:0];

`ifdef LEADING_BLANK_EN
    logic lead;

    always_comb begin
        seg_new = '0;
        lead    = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            if (lead && (i != 0) && (bcd_sh[4*i +: 4] == 4'd0)) begin
                seg_new[7*i +: 7] = 7'b0000000;
            end else begin
                lead              = 1'b0;
                seg_new[7*i +: 7] = seg7(bcd_sh[4*i +: 4]);
            end
        end
    end
`else
    always_comb begin
        seg_new = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            seg_new[7*i +: 7] = seg7(bcd_sh[4*i +: 4]);
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        mode_d     = mode_q;
        acc_d      = acc_q;
        k_d        = k_q;
        presc_d    = presc_q;
        ovf_int_d  = ovf_int_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        bit_cnt_d  = bit_cnt_q;
        seg_d      = seg_q;
        overflow_d = overflow_q;

        case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d   = StSum;
                    count_d   = count;
                    mode_d    = mode;
                    acc_d     = '0;
                    k_d       = '0;
                    presc_d   = '0;
                    ovf_int_d = 1'b0;
                end
            end
            StSum: begin
                if (!enable) begin
                    state_d = StIdle;
                end else begin
                    presc_d = strobe ? '0 : presc_q + PRESC_W'(1);
                    if (strobe) begin
                        if (k_q <= {1'b0, count_q}) begin
                            acc_d = sum_sat ? SAT : sum[SUM_W-1:0];
                            k_d   = k_q + K_W'(1);
                            if (sum_sat) begin
                                ovf_int_d = 1'b1;
                            end
                        end else begin
                            state_d   = StConv;
                            bin_d     = acc_q;
                            bcd_d     = '0;
                            bit_cnt_d = '0;
                        end
                    end
                end
            end
            StConv: begin
                if (!enable) begin
                    state_d = StIdle;
                end else begin
                    bin_d     = bin_sh;
                    bcd_d     = bcd_sh;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(SUM_W - 1)) begin
                        state_d    = StPrint;
                        seg_d      = seg_new;
                        overflow_d = ovf_int_q;
                    end
                end
            end
            default: begin
                if (!enable) begin
                    state_d = StIdle;
                end
            end
        endcase

        busy_d = (state_d == StSum) || (state_d == StConv);
        done_d = (state_d == StPrint);
    end

    always_ff @(posedge clk) begin
        if (rst_a_p) begin
            state_q    <= StIdle;
            count_q    <= '0;
            mode_q     <= '0;
            acc_q      <= '0;
            k_q        <= '0;
            presc_q    <= '0;
            ovf_int_q  <= 1'b0;
            bin_q      <= '0;
            bcd_q      <= '0;
            bit_cnt_q  <= '0;
            seg_q      <= SEG_RESET;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            mode_q     <= mode_d;
            acc_q      <= acc_d;
            k_q        <= k_d;
            presc_q    <= presc_d;
            ovf_int_q  <= ovf_int_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            bit_cnt_q  <= bit_cnt_d;
            seg_q      <= seg_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign seg      = seg_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_series_accumulator.sv
// Bench for series_accumulator: directed and random runs checked against an arithmetic
// series/decimal model through a scoreboard popped whenever done rises.
`timescale 1ns/1ps
module tb_series_accumulator;

    localparam int unsigned N_BITS   = 4;
    localparam int unsigned SUM_W    = 8;
    localparam int unsigned DIGITS   = 3;
    localparam int unsigned STEP_DIV = 1;
    localparam int unsigned SEG_W    = 7 * DIGITS;
    localparam int          SAT      = (1 << SUM_W) - 1;

    localparam logic [6:0] CODES [0:9] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };

    typedef struct packed {
        logic [SEG_W-1:0] seg;
        logic             ovf;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_a_p;
    logic              enable;
    logic [N_BITS-1:0] count;
    logic [1:0]        mode;
    logic [SEG_W-1:0]  seg;
    logic              busy;
    logic              done;
    logic              overflow;

    exp_t             exp_q[$];
    exp_t             mon_x;
    logic             done_prev = 1'b0;
    logic [SEG_W-1:0] last_seg;
    logic             last_ovf;
    int               vectors     = 0;
    int               miscompares = 0;

    series_accumulator #(
        .N_BITS  (N_BITS),
        .SUM_W   (SUM_W),
        .DIGITS  (DIGITS),
        .STEP_DIV(STEP_DIV)
    ) dut (
        .clk     (clk),
        .rst_a_p (rst_a_p),
        .enable  (enable),
        .count   (count),
        .mode    (mode),
        .seg     (seg),
        .busy    (busy),
        .done    (done),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic int series_total(input int m, input int c);
        int t = 0;
        for (int k = 0; k <= c; k++) begin
            case (m)
                0:       t += k;
                1:       t += k * k;
                2:       t += 2 * k + 1;
                default: t += 2 * k;
            endcase
        end
        return t;
    endfunction

    function automatic logic [SEG_W-1:0] display(input int v);
        logic [SEG_W-1:0] s = '0;
        int p = 1;
        for (int i = 0; i < int'(DIGITS); i++) begin
`ifdef LEADING_BLANK_EN
            if (i > 0 && v < p) s[7*i +: 7] = 7'b0000000;
            else                s[7*i +: 7] = CODES[(v / p) % 10];
`else
            s[7*i +: 7] = CODES[(v / p) % 10];
`endif
            p = p * 10;
        end
        return s;
    endfunction

    // Scoreboard monitor: every rising edge of done must match the oldest queued result.
    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got done=1 with no run queued, expected none");
            end else begin
                mon_x = exp_q.pop_front();
                check("sb_seg", 64'(seg), 64'(mon_x.seg));
                check("sb_overflow", 64'(overflow), 64'(mon_x.ovf));
            end
        end
        done_prev <= done;
    end

    task automatic run(input int m, input int c, input bit poke);
        int   total;
        int   e;
        exp_t x;
        total = series_total(m, c);
        x.ovf = (total > SAT);
        x.seg = display((total > SAT) ? SAT : total);
        exp_q.push_back(x);
        mode   = 2'(m);
        count  = N_BITS'(c);
        enable = 1'b1;
        @(posedge clk); #1;
        check("busy_in_sum", 64'(busy), 64'd1);
        e = 0;
        while (!done && e < 400) begin
            @(posedge clk); #1;
            e++;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: got no done after %0d edges, expected done", e);
        end else begin
            check("latency", 64'(e), 64'(c + 2 + int'(SUM_W)));
        end
        if (poke) begin
            mode  = ~mode;
            count = ~count;
            repeat (3) @(posedge clk);
            #1;
            check("print_seg_hold", 64'(seg), 64'(x.seg));
            check("print_done_hold", 64'(done), 64'd1);
        end
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        enable = 1'b0;
        @(posedge clk); #1;
        check("idle_done", 64'(done), 64'd0);
        check("idle_seg_kept", 64'(seg), 64'(x.seg));
        last_seg = x.seg;
        last_ovf = x.ovf;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a_p = 1'b1;
        enable  = 1'b0;
        count   = '0;
        mode    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_a_p = 1'b0;
        check("reset_seg", 64'(seg), 64'(display(0)));
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_overflow", 64'(overflow), 64'd0);
        last_seg = display(0);
        last_ovf = 1'b0;

        run(0, 4, 1'b1);
        run(0, 15, 1'b0);
        run(1, 5, 1'b0);
        run(2, 3, 1'b0);
        run(1, 15, 1'b0);
        run(0, 2, 1'b0);

        // Abort mid-SUM: next edge is IDLE with the previous display intact.
        mode = 2'd0; count = 4'd4; enable = 1'b1;
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy_before", 64'(busy), 64'd1);
        enable = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_seg", 64'(seg), 64'(last_seg));
        check("abort_overflow", 64'(overflow), 64'(last_ovf));
        run(0, 4, 1'b0);

        for (int r = 0; r < 25; r++) begin
            run(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        // Overflowed result, then reset in the middle of the conversion.
        run(1, 15, 1'b0);
        mode = 2'd0; count = 4'd4; enable = 1'b1;
        @(posedge clk); #1;
        repeat (9) @(posedge clk);
        #1;
        check("conv_busy", 64'(busy), 64'd1);
        rst_a_p = 1'b1;
        @(posedge clk); #1;
        rst_a_p = 1'b0;
        enable  = 1'b0;
        check("midconv_reset_busy", 64'(busy), 64'd0);
        check("midconv_reset_done", 64'(done), 64'd0);
        check("midconv_reset_seg", 64'(seg), 64'(display(0)));
        check("midconv_reset_overflow", 64'(overflow), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
